// File: rtl/dkong_hiscore_engine.sv
// rtl/dkong_hiscore_engine.sv - high-score restore/dump initiator for the dkong_top hs_* side port
// Waits for a ready signature in game RAM, restores the host table, and dumps it back on request.
module dkong_hiscore_engine #(
    parameter logic [15:0] BASE_ADDR    = 16'h6100,
    parameter logic [8:0]  LENGTH       = 9'd168,
    parameter logic [15:0] CHECK_ADDR   = 16'h6100,
    parameter logic [7:0]  CHECK_VALUE  = 8'h00,
    parameter logic [3:0]  CHECK_FRAMES = 4'd4
) (
    input  logic        I_CLK_24576M,
    input  logic        I_RESET,
    input  logic        I_VBLANK,
    input  logic [7:0]  I_DL_ADDR,
    input  logic [7:0]  I_DL_DATA,
    input  logic        I_DL_WR,
    input  logic        I_DL_DONE,
    input  logic [7:0]  I_UL_ADDR,
    output logic [7:0]  O_UL_DATA,
    input  logic        I_SAVE_REQ,
    output logic        O_SAVE_DONE,
    output logic [15:0] O_HS_ADDRESS,
    output logic [7:0]  O_HS_DATA,
    input  logic [7:0]  I_HS_DATA,
    output logic        O_HS_WRITE,
    output logic        O_HS_ACCESS,
    output logic        O_RESTORED,
    output logic        O_BUSY
);

    typedef enum logic [2:0] {S_IDLE, S_CHECK, S_RESTORE, S_READY, S_DUMP} state_t;

    state_t      state, state_next;
    logic [7:0]  buf_mem [0:255];
    logic [7:0]  ul_data;
    logic [8:0]  index;
    logic [1:0]  phase;
    logic [3:0]  match_cnt;
    logic        buf_valid, save_pend, restored, save_done;
    logic        vblank_q, run_q, chk_pend;
    logic        vblank_rise, win, op_active, active, last_phase, last_byte;
    logic        host_ok, check_sample, dump_wr, hs_write_c;
    logic [15:0] hs_addr_c;

    // A transfer window opens only on a vblank rising edge and closes on any state change,
    // so every restore/dump burst starts at the top of a fresh vblank.
    assign vblank_rise = I_VBLANK & ~vblank_q;
    assign win         = I_VBLANK & (vblank_rise | run_q);
    assign last_byte   = (index == LENGTH - 9'd1);
    assign host_ok     = (state == S_IDLE) || (state == S_CHECK);

    always_ff @(posedge I_CLK_24576M) begin
        if (I_RESET) state <= S_IDLE;
        else         state <= state_next;
    end

    always_comb begin
        state_next   = state;
        op_active    = 1'b0;
        last_phase   = 1'b0;
        hs_write_c   = 1'b0;
        hs_addr_c    = BASE_ADDR + {7'd0, index};
        check_sample = 1'b0;
        dump_wr      = 1'b0;
        case (state)
            S_IDLE: state_next = S_CHECK;
            S_CHECK: begin
                op_active  = chk_pend | vblank_rise;
                hs_addr_c  = CHECK_ADDR;
                last_phase = (phase == 2'd2);
                if (op_active && win && last_phase) begin
                    check_sample = 1'b1;
                    if (I_HS_DATA == CHECK_VALUE && match_cnt + 4'd1 == CHECK_FRAMES)
                        state_next = buf_valid ? S_RESTORE : S_READY;
                end
            end
            S_RESTORE: begin
                op_active  = 1'b1;
                last_phase = (phase == 2'd1);
                hs_write_c = (phase == 2'd0);
                if (win && last_phase && last_byte) state_next = S_READY;
            end
            S_READY: begin
                if (I_SAVE_REQ || save_pend) state_next = S_DUMP;
            end
            S_DUMP: begin
                op_active  = 1'b1;
                last_phase = (phase == 2'd2);
                if (win && last_phase) begin
                    dump_wr = 1'b1;
                    if (last_byte) state_next = S_READY;
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    assign active = op_active & win;

    always_ff @(posedge I_CLK_24576M) begin
        if (I_RESET) begin
            ul_data   <= 8'h00;
            index     <= 9'd0;
            phase     <= 2'd0;
            match_cnt <= 4'd0;
            buf_valid <= 1'b0;
            save_pend <= 1'b0;
            restored  <= 1'b0;
            save_done <= 1'b0;
            vblank_q  <= 1'b0;
            run_q     <= 1'b0;
            chk_pend  <= 1'b0;
        end else begin
            vblank_q <= I_VBLANK;
            run_q    <= win && (state_next == state);
            // Losing vblank mid-byte drops the phase back to c0 without advancing the index.
            phase    <= (active && !last_phase) ? phase + 2'd1 : 2'd0;
            if (active && last_phase && (state == S_RESTORE || state == S_DUMP))
                index <= last_byte ? 9'd0 : index + 9'd1;
            if (state == S_CHECK) begin
                if (check_sample)     chk_pend <= 1'b0;
                else if (vblank_rise) chk_pend <= 1'b1;
            end else begin
                chk_pend <= 1'b0;
            end
            if (check_sample)
                match_cnt <= (I_HS_DATA == CHECK_VALUE) ? match_cnt + 4'd1 : 4'd0;
            if (host_ok && I_DL_DONE) buf_valid <= 1'b1;
            if (state == S_READY)  save_pend <= 1'b0;
            else if (I_SAVE_REQ)   save_pend <= 1'b1;
            if ((state == S_CHECK || state == S_RESTORE) && state_next == S_READY)
                restored <= 1'b1;
            save_done <= (state == S_DUMP) && (state_next == S_READY);
            ul_data   <= buf_mem[I_UL_ADDR];
        end
    end

    always_ff @(posedge I_CLK_24576M) begin
        if (host_ok && I_DL_WR)
            buf_mem[I_DL_ADDR] <= I_DL_DATA;
        else if (dump_wr)
            buf_mem[index[7:0]] <= I_HS_DATA;
    end

    assign O_HS_ACCESS  = active;
    assign O_HS_WRITE   = active & hs_write_c;
    assign O_HS_ADDRESS = active ? hs_addr_c : 16'h0000;
    assign O_HS_DATA    = (active & hs_write_c) ? buf_mem[index[7:0]] : 8'h00;
    assign O_UL_DATA    = ul_data;
    assign O_SAVE_DONE  = save_done;
    assign O_RESTORED   = restored;
    assign O_BUSY       = (state == S_CHECK) || (state == S_RESTORE) || (state == S_DUMP);

endmodule

// File: tb/tb_dkong_hiscore_engine.sv
// tb/tb_dkong_hiscore_engine.sv - directed self-checking bench for dkong_hiscore_engine
module tb_dkong_hiscore_engine;

    logic        clk = 1'b0;
    logic        rst, vblank, dl_wr, dl_done, save_req;
    logic [7:0]  dl_addr, dl_data, ul_addr, hs_rdata;
    logic [7:0]  ul_data, hs_data;
    logic [15:0] hs_addr;
    logic        save_done, hs_write, hs_access, restored, busy;

    int passed = 0;
    int total  = 0;

    logic vb_en = 1'b0;
    int   vb_len = 60;
    int   vb_gap = 40;
    logic chk_mode = 1'b1;
    int   mis_at = -1;
    logic clr = 1'b0;

    int          rises = 0, wr_total = 0, viol = 0, bad_addr = 0, save_cnt = 0;
    int          first_wr_rise = -1, rises_at_restored = 0, gap = 0;
    logic        restored_seen = 1'b0, vb_prev = 1'b0;
    int          wr_cnt [256];
    logic [7:0]  wr_dat [256];

    always #20 clk = ~clk;

    dkong_hiscore_engine dut (
        .I_CLK_24576M (clk),
        .I_RESET      (rst),
        .I_VBLANK     (vblank),
        .I_DL_ADDR    (dl_addr),
        .I_DL_DATA    (dl_data),
        .I_DL_WR      (dl_wr),
        .I_DL_DONE    (dl_done),
        .I_UL_ADDR    (ul_addr),
        .O_UL_DATA    (ul_data),
        .I_SAVE_REQ   (save_req),
        .O_SAVE_DONE  (save_done),
        .O_HS_ADDRESS (hs_addr),
        .O_HS_DATA    (hs_data),
        .I_HS_DATA    (hs_rdata),
        .O_HS_WRITE   (hs_write),
        .O_HS_ACCESS  (hs_access),
        .O_RESTORED   (restored),
        .O_BUSY       (busy)
    );

    // Target RAM model: ready signature (with one optional bad vblank) or the A0+i table.
    always_comb begin
        if (chk_mode) hs_rdata = (rises == mis_at) ? 8'h12 : 8'h00;
        else          hs_rdata = 8'hA0 + hs_addr[7:0];
    end

    initial begin
        vblank = 1'b0;
        forever begin
            @(posedge clk); #1;
            if (vb_en) begin
                vblank = 1'b1;
                repeat (vb_len) @(posedge clk);
                #1 vblank = 1'b0;
                repeat (vb_gap - 1) @(posedge clk);
            end
        end
    end

    always @(negedge clk) begin
        if (clr) begin
            rises = 0; wr_total = 0; viol = 0; bad_addr = 0; save_cnt = 0;
            first_wr_rise = -1; rises_at_restored = 0; gap = 0; restored_seen = 1'b0;
            for (int i = 0; i < 256; i++) begin
                wr_cnt[i] = 0;
                wr_dat[i] = 8'h00;
            end
        end else begin
            if (vblank && !vb_prev) rises++;
            if (hs_access && !vblank) viol++;
            if (hs_write && !hs_access) viol++;
            if (hs_write) begin
                if (first_wr_rise < 0) first_wr_rise = rises;
                wr_total++;
                if (hs_addr[15:8] == 8'h61) begin
                    wr_cnt[hs_addr[7:0]]++;
                    wr_dat[hs_addr[7:0]] = hs_data;
                end else begin
                    bad_addr++;
                end
            end
            if (restored && !restored_seen) begin
                restored_seen = 1'b1;
                rises_at_restored = rises;
            end
            if (restored && !busy && !save_done && save_cnt == 0) gap++;
            if (save_done) save_cnt++;
        end
        vb_prev = vblank;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // sel: 0 restored, 1 save_done, 2 access, 3 vblank low
    task automatic wait_for(input string tag, input int sel, input int budget);
        bit hit;
        hit = 1'b0;
        for (int n = 0; n < budget; n++) begin
            @(negedge clk);
            if ((sel == 0 && restored) || (sel == 1 && save_done) ||
                (sel == 2 && hs_access) || (sel == 3 && !vblank)) begin
                hit = 1'b1;
                break;
            end
        end
        chk(tag, {31'd0, hit}, 32'd1);
    endtask

    task automatic host_wr(input logic [7:0] a, input logic [7:0] d);
        @(posedge clk); #1;
        dl_addr = a; dl_data = d; dl_wr = 1'b1;
        @(posedge clk); #1;
        dl_wr = 1'b0;
    endtask

    task automatic pulse_done();
        @(posedge clk); #1 dl_done = 1'b1;
        @(posedge clk); #1 dl_done = 1'b0;
    endtask

    task automatic pulse_save();
        @(posedge clk); #1 save_req = 1'b1;
        @(posedge clk); #1 save_req = 1'b0;
    endtask

    task automatic clear_mon();
        @(posedge clk); #1 clr = 1'b1;
        @(posedge clk); #1 clr = 1'b0;
    endtask

    task automatic do_reset();
        @(posedge clk); #1 rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic ul_read(input logic [7:0] a, output logic [7:0] d);
        @(posedge clk); #1 ul_addr = a;
        @(posedge clk);
        @(negedge clk);
        d = ul_data;
    endtask

    // pattern 0: i^5A, pattern 1: A0+i; addresses beyond the table must stay unwritten
    task automatic table_errs(input bit pat, output int errs);
        logic [7:0] e;
        errs = 0;
        for (int i = 0; i < 256; i++) begin
            e = pat ? 8'(8'hA0 + i) : 8'(i ^ 8'h5A);
            if (i < 168) begin
                if (wr_cnt[i] != 1 || wr_dat[i] != e) errs++;
            end else if (wr_cnt[i] != 0) begin
                errs++;
            end
        end
    endtask

    initial begin
        logic [7:0] rd;
        int errs;
        rst = 1'b1; dl_wr = 1'b0; dl_done = 1'b0; save_req = 1'b0;
        dl_addr = 8'h00; dl_data = 8'h00; ul_addr = 8'h00;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_access",   {31'd0, hs_access}, 32'd0);
        chk("rst_write",    {31'd0, hs_write}, 32'd0);
        chk("rst_addr",     {16'd0, hs_addr}, 32'd0);
        chk("rst_data",     {24'd0, hs_data}, 32'd0);
        chk("rst_restored", {31'd0, restored}, 32'd0);
        chk("rst_busy",     {31'd0, busy}, 32'd0);
        chk("rst_savedone", {31'd0, save_done}, 32'd0);
        chk("rst_uldata",   {24'd0, ul_data}, 32'd0);
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("check_busy", {31'd0, busy}, 32'd1);

        // Ready detection and full restore inside one long vblank
        for (int i = 0; i < 168; i++) host_wr(8'(i), 8'(i ^ 8'h5A));
        host_wr(8'd200, 8'h11);
        pulse_done();
        clear_mon();
        vb_len = 400; vb_gap = 40; vb_en = 1'b1;
        wait_for("t1_restored_timeout", 0, 6000);
        vb_en = 1'b0;
        repeat (3) @(negedge clk);
        chk("t1_write_count", wr_total, 32'd168);
        table_errs(1'b0, errs);
        chk("t1_table", errs, 32'd0);
        chk("t1_vblank_viol", viol, 32'd0);
        chk("t1_bad_addr", bad_addr, 32'd0);
        chk("t1_after_4th", {31'd0, first_wr_rise > 4}, 32'd1);
        chk("t1_restored", {31'd0, restored}, 32'd1);
        chk("t1_ready_idle", {31'd0, busy}, 32'd0);

        // Host writes outside IDLE/CHECK are dropped; upload port works in READY
        host_wr(8'd200, 8'h99);
        ul_read(8'd200, rd);
        chk("drop_write", {24'd0, rd}, 32'h11);
        ul_read(8'd5, rd);
        chk("ul_read_5", {24'd0, rd}, 32'h5F);

        // No host data: flag set after the 4th matching vblank, no writes
        wait_for("t2_vblank_low", 3, 1000);
        vb_len = 60; vb_gap = 40;
        do_reset();
        clear_mon();
        vb_en = 1'b1;
        wait_for("t2_restored_timeout", 0, 1500);
        vb_en = 1'b0;
        repeat (3) @(negedge clk);
        chk("t2_no_writes", wr_total, 32'd0);
        chk("t2_restored_at_4", rises_at_restored, 32'd4);
        chk("t2_restored", {31'd0, restored}, 32'd1);

        // Mismatch on the 3rd vblank, then restore through 60-cycle vblank windows
        wait_for("t3_vblank_low", 3, 1000);
        do_reset();
        pulse_done();
        mis_at = 3;
        clear_mon();
        vb_en = 1'b1;
        wait_for("t3_restored_timeout", 0, 4000);
        vb_en = 1'b0;
        mis_at = -1;
        repeat (3) @(negedge clk);
        chk("t3_after_7th", {31'd0, first_wr_rise > 7}, 32'd1);
        chk("t3_write_count", wr_total, 32'd168);
        table_errs(1'b0, errs);
        chk("t3_table_once", errs, 32'd0);
        chk("t3_vblank_viol", viol, 32'd0);

        // Dump through 62-cycle windows (partial reads abandoned at each window end)
        wait_for("t5_vblank_low", 3, 1000);
        chk_mode = 1'b0;
        clear_mon();
        vb_len = 62; vb_en = 1'b1;
        pulse_save();
        wait_for("t5_savedone_timeout", 1, 3000);
        vb_en = 1'b0;
        repeat (4) @(negedge clk);
        chk("t5_save_pulse", save_cnt, 32'd1);
        chk("t5_no_writes", wr_total, 32'd0);
        chk("t5_vblank_viol", viol, 32'd0);
        chk("t5_idle", {31'd0, busy}, 32'd0);
        ul_read(8'd7, rd);
        chk("t5_ul_7", {24'd0, rd}, 32'hA7);
        ul_read(8'd0, rd);
        chk("t5_ul_0", {24'd0, rd}, 32'hA0);
        ul_read(8'd167, rd);
        chk("t5_ul_167", {24'd0, rd}, 32'h47);

        // Reset mid-dump, then save requested during CHECK
        wait_for("t6_vblank_low", 3, 1000);
        vb_en = 1'b1;
        pulse_save();
        wait_for("t6_access_timeout", 2, 500);
        repeat (5) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("t6_rst_access", {31'd0, hs_access}, 32'd0);
        chk("t6_rst_write", {31'd0, hs_write}, 32'd0);
        chk("t6_rst_addr", {16'd0, hs_addr}, 32'd0);
        chk("t6_rst_busy", {31'd0, busy}, 32'd0);
        chk("t6_rst_restored", {31'd0, restored}, 32'd0);
        @(posedge clk); #1 rst = 1'b0;
        chk_mode = 1'b1;
        clear_mon();
        pulse_done();
        pulse_save();
        wait_for("t6_restored_timeout", 0, 4000);
        @(posedge clk); #1 chk_mode = 1'b0;
        wait_for("t6_savedone_timeout", 1, 3000);
        vb_en = 1'b0;
        repeat (4) @(negedge clk);
        chk("t6_write_count", wr_total, 32'd168);
        table_errs(1'b1, errs);
        chk("t6_table", errs, 32'd0);
        chk("t6_dump_follows", gap, 32'd1);
        chk("t6_save_pulse", save_cnt, 32'd1);
        chk("t6_vblank_viol", viol, 32'd0);
        ul_read(8'd7, rd);
        chk("t6_ul_7", {24'd0, rd}, 32'hA7);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
